// File: rtl/pattern_decoder_seq.sv
// Registered binary-to-one-hot decoder with valid/ready on both sides,
// an error flag for out-of-range codes, and a handshaked SCAN walker.
// Ports: clk, rst_n (async, active-low)
//   in:  in_valid, in_code[IN_W], in_en, scan_start, scan_stop, out_ready
//   out: in_ready, out_valid, out_onehot[OUT_N], out_err, busy
module pattern_decoder_seq #(
  parameter int IN_W      = 2,
  parameter int OUT_N     = 3,
  parameter int SCAN_WRAP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_code,
  input  logic             in_en,
  input  logic             scan_start,
  input  logic             scan_stop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_N-1:0] out_onehot,
  output logic             out_err,
  output logic             busy
);

  localparam int IW = (OUT_N > 1) ? $clog2(OUT_N) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  localparam logic [OUT_N-1:0] ONE  = OUT_N'(1);
  localparam logic [IW-1:0]    LAST = IW'(OUT_N - 1);
  localparam logic [IN_W:0]    LIM  = (IN_W + 1)'(OUT_N);

  logic [0:0]       r_state;
  logic             r_valid;
  logic [OUT_N-1:0] r_onehot;
  logic             r_err;
  logic [IW-1:0]    r_idx;
  logic             r_stop_pend;

  logic             w_free;
  logic             w_idle;
  logic             w_accept;
  logic             w_code_ok;
  logic [OUT_N-1:0] w_dec;
  logic             w_dec_err;
  logic             w_beat;
  logic             w_stop_now;
  logic             w_last;
  logic [IW-1:0]    w_idx_nxt;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_free   = !r_valid || out_ready;
  assign in_ready = w_idle && w_free && !scan_start;
  assign w_accept = in_valid && in_ready;

  // Widen the code by one bit so OUT_N == 2**IN_W still compares cleanly.
  assign w_code_ok = ({1'b0, in_code} < LIM);
  assign w_dec     = (in_en && w_code_ok) ? (ONE << in_code) : '0;
  assign w_dec_err = in_en && !w_code_ok;

  assign w_beat     = r_valid && out_ready;
  assign w_stop_now = r_stop_pend || scan_stop;
  assign w_last     = (r_idx == LAST);
  assign w_idx_nxt  = w_last ? '0 : r_idx + IW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_valid     <= 1'b0;
      r_onehot    <= '0;
      r_err       <= 1'b0;
      r_idx       <= '0;
      r_stop_pend <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Scan request outranks a pending input beat.
          if (scan_start && w_free) begin
            r_state  <= ST_SCAN;
            r_valid  <= 1'b1;
            r_onehot <= ONE;
            r_err    <= 1'b0;
            r_idx    <= '0;
          end else if (w_accept) begin
            r_valid  <= 1'b1;
            r_onehot <= w_dec;
            r_err    <= w_dec_err;
          end else if (out_ready) begin
            r_valid  <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (w_beat) begin
            if (w_stop_now) begin
              r_valid     <= 1'b0;
              r_state     <= ST_IDLE;
              r_stop_pend <= 1'b0;
            end else if (SCAN_WRAP == 0 && w_last) begin
              r_valid <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_idx    <= w_idx_nxt;
              r_onehot <= ONE << w_idx_nxt;
            end
          end else if (scan_stop) begin
            r_stop_pend <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid  = r_valid;
  assign out_onehot = r_onehot;
  assign out_err    = r_err;
  assign busy       = (r_state == ST_SCAN);

endmodule

// File: tb/tb_pattern_decoder_seq.sv
// Directed bench for pattern_decoder_seq: decode, backpressure,
// scan with and without wrap, stop handling and async reset.
module tb_pattern_decoder_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_en, scan_start, scan_stop, out_ready;
  logic [1:0] in_code;

  logic       rdy1, vld1, err1, busy1;
  logic [2:0] oh1;
  logic       rdy0, vld0, err0, busy0;
  logic [2:0] oh0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pattern_decoder_seq #(.IN_W(2), .OUT_N(3), .SCAN_WRAP(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy1),
    .in_code(in_code), .in_en(in_en),
    .scan_start(scan_start), .scan_stop(scan_stop),
    .out_valid(vld1), .out_ready(out_ready),
    .out_onehot(oh1), .out_err(err1), .busy(busy1)
  );

  pattern_decoder_seq #(.IN_W(2), .OUT_N(3), .SCAN_WRAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy0),
    .in_code(in_code), .in_en(in_en),
    .scan_start(scan_start), .scan_stop(scan_stop),
    .out_valid(vld0), .out_ready(out_ready),
    .out_onehot(oh0), .out_err(err0), .busy(busy0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid   = 1'b0;
    in_en      = 1'b0;
    in_code    = '0;
    scan_start = 1'b0;
    scan_stop  = 1'b0;
    out_ready  = 1'b0;
    rst_n      = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    in_valid = 0; in_en = 0; in_code = 0;
    scan_start = 0; scan_stop = 0; out_ready = 0;
    rst_n = 1'b0;
    #3;
    n_tests++;
    if ({vld1, oh1, err1, busy1} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outs got %b want 000000",
               {vld1, oh1, err1, busy1});
    end
    n_tests++;
    if (rdy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready got %b want 1", rdy1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_decode();
    logic [2:0] exp_oh [5];
    logic       exp_er [5];
    logic [1:0] codes  [5];
    logic       ens    [5];
    exp_oh = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b000};
    exp_er = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    codes  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
    ens    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_code = codes[i];
      in_en   = ens[i];
      step();
      n_tests++;
      if ({vld1, oh1, err1} !== {1'b1, exp_oh[i], exp_er[i]}) begin
        n_fail++;
        $display("FAIL decode_%0d got v/oh/err %b want %b", i,
                 {vld1, oh1, err1}, {1'b1, exp_oh[i], exp_er[i]});
      end
    end
    in_valid = 1'b0;
    step();
    n_tests++;
    if (vld1 !== 1'b0) begin
      n_fail++;
      $display("FAIL decode_drain got %b want 0", vld1);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_en     = 1'b1;
    in_code   = 2'd1;
    step();
    in_code = 2'd2;
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if ({vld1, oh1, rdy1} !== 5'b1_010_0) begin
        n_fail++;
        $display("FAIL bp_hold_%0d got v/oh/rdy %b want 10100", i,
                 {vld1, oh1, rdy1});
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    n_tests++;
    if (rdy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release_rdy got %b want 1", rdy1);
    end
    step();
    in_valid = 1'b0;
    n_tests++;
    if ({vld1, oh1} !== 4'b1_100) begin
      n_fail++;
      $display("FAIL bp_next got v/oh %b want 1100", {vld1, oh1});
    end
    step();
  endtask

  task automatic test_scan_wrap();
    logic [2:0] exp_oh [5];
    exp_oh = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    out_ready  = 1'b1;
    scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if ({vld1, busy1, oh1, err1} !== {2'b11, exp_oh[i], 1'b0}) begin
        n_fail++;
        $display("FAIL scan_wrap_%0d got v/busy/oh/err %b want %b", i,
                 {vld1, busy1, oh1, err1}, {2'b11, exp_oh[i], 1'b0});
      end
      if (i == 4) scan_stop = 1'b1;
      step();
      scan_stop = 1'b0;
    end
    n_tests++;
    if ({vld1, busy1, rdy1} !== 3'b001) begin
      n_fail++;
      $display("FAIL scan_wrap_stop got v/busy/rdy %b want 001",
               {vld1, busy1, rdy1});
    end
  endtask

  task automatic test_scan_single();
    logic [2:0] exp_oh [3];
    exp_oh = '{3'b001, 3'b010, 3'b100};
    out_ready  = 1'b1;
    scan_start = 1'b1;
    in_valid   = 1'b1;
    in_en      = 1'b1;
    in_code    = 2'd2;
    #1;
    n_tests++;
    if (rdy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL scan_prio_rdy got %b want 0", rdy0);
    end
    step();
    scan_start = 1'b0;
    in_valid   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({vld0, busy0, oh0} !== {2'b11, exp_oh[i]}) begin
        n_fail++;
        $display("FAIL scan_single_%0d got v/busy/oh %b want %b", i,
                 {vld0, busy0, oh0}, {2'b11, exp_oh[i]});
      end
      step();
    end
    n_tests++;
    if ({vld0, busy0} !== 2'b00) begin
      n_fail++;
      $display("FAIL scan_single_end got v/busy %b want 00",
               {vld0, busy0});
    end
  endtask

  task automatic test_stop_pending();
    out_ready  = 1'b0;
    scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    scan_stop  = 1'b1;
    step();
    scan_stop = 1'b0;
    step();
    n_tests++;
    if ({vld1, busy1, oh1} !== 5'b11_001) begin
      n_fail++;
      $display("FAIL stop_pend_hold got v/busy/oh %b want 11001",
               {vld1, busy1, oh1});
    end
    out_ready = 1'b1;
    step();
    n_tests++;
    if ({vld1, busy1} !== 2'b00) begin
      n_fail++;
      $display("FAIL stop_pend_exit got v/busy %b want 00",
               {vld1, busy1});
    end
  endtask

  task automatic test_reset_mid_scan();
    out_ready  = 1'b1;
    scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    step();
    n_tests++;
    if ({busy1, oh1} !== 4'b1_010) begin
      n_fail++;
      $display("FAIL midscan_pre got busy/oh %b want 1010", {busy1, oh1});
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({vld1, oh1, busy1, rdy1} !== 6'b0_000_0_1) begin
      n_fail++;
      $display("FAIL midscan_rst got v/oh/busy/rdy %b want 000001",
               {vld1, oh1, busy1, rdy1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_tests++;
    if ({vld1, busy1, rdy1} !== 3'b001) begin
      n_fail++;
      $display("FAIL midscan_after got v/busy/rdy %b want 001",
               {vld1, busy1, rdy1});
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_backpressure();
    do_reset();
    test_scan_wrap();
    do_reset();
    test_scan_single();
    do_reset();
    test_stop_pending();
    do_reset();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
